// File: rtl/pattern_generator.sv
// Golden-reference FP32 add/sub/mul/div unit with fixed latency.
// Operands are captured on a start pulse. The result, with its Overflow and
// Error flags, is published LATENCY clock edges after the capture edge.
// Denormal inputs are flushed to signed zero, and a tiny result becomes signed zero.
module pattern_generator #(
    parameter int LATENCY = 3
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [1:0]  Sel,
    input  logic [1:0]  round,
    input  logic        start,
    output logic        Error,
    output logic        Overflow,
    output logic [31:0] Y,
    input  logic        genonly
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [7:0]  CNT_LAST = 8'(LATENCY - 2);
    localparam logic [31:0] QNAN     = 32'h7FC0_0000;
    localparam logic [30:0] INF_MAG  = 31'h7F80_0000;
    localparam logic [30:0] MAX_MAG  = 31'h7F7F_FFFF;

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] a_q, b_q;
    logic [1:0]  sel_q, round_q;

    // Count leading zeros of the 27-bit subtraction result (27 when zero)
    function automatic logic [4:0] clz27(input logic [26:0] v);
        logic found;
        clz27 = 5'd0;
        found = 1'b0;
        for (int i = 26; i >= 0; i--) begin
            if (found) begin
                found = 1'b1;
            end else if (v[i]) begin
                found = 1'b1;
            end else begin
                clz27 = clz27 + 5'd1;
            end
        end
    endfunction

    // ---------------- operand decode ----------------
    logic        sa_s, sb_s, sbe_s;
    logic [7:0]  ea_s, eb_s;
    logic [22:0] fa_s, fb_s;
    logic        a_zero_s, b_zero_s, a_inf_s, b_inf_s, a_nan_s, b_nan_s;
    logic [23:0] ma_s, mb_s;
    logic signed [11:0] ea_x_s, eb_x_s;

    assign sa_s     = a_q[31];
    assign ea_s     = a_q[30:23];
    assign fa_s     = a_q[22:0];
    assign sb_s     = b_q[31];
    assign eb_s     = b_q[30:23];
    assign fb_s     = b_q[22:0];
    assign sbe_s    = sb_s ^ (sel_q == 2'b01);
    assign a_zero_s = (ea_s == 8'd0);
    assign b_zero_s = (eb_s == 8'd0);
    assign a_inf_s  = (ea_s == 8'hFF) && (fa_s == 23'd0);
    assign b_inf_s  = (eb_s == 8'hFF) && (fb_s == 23'd0);
    assign a_nan_s  = (ea_s == 8'hFF) && (fa_s != 23'd0);
    assign b_nan_s  = (eb_s == 8'hFF) && (fb_s != 23'd0);
    assign ma_s     = a_zero_s ? 24'd0 : {1'b1, fa_s};
    assign mb_s     = b_zero_s ? 24'd0 : {1'b1, fb_s};
    assign ea_x_s   = $signed({4'd0, ea_s});
    assign eb_x_s   = $signed({4'd0, eb_s});

    // ---------------- add/sub datapath ----------------
    // Magnitudes are ordered so the subtraction never goes negative. The
    // smaller operand is aligned into 24 mantissa bits plus guard, round
    // and a sticky LSB.
    logic        a_ge_s, big_sign_s, eff_sub_s;
    logic [23:0] big_m_s, small_m_s;
    logic [7:0]  big_e_s, small_e_s, exp_diff_s;
    logic [4:0]  shamt_s, lz_s;
    logic [50:0] shifted_s;
    logic [26:0] big27_s, small27_s, diff_s, diff_norm_s;
    logic [27:0] sum_s;
    logic signed [11:0] big_x_s;

    assign a_ge_s      = {ea_s, fa_s} >= {eb_s, fb_s};
    assign big_m_s     = a_ge_s ? ma_s : mb_s;
    assign small_m_s   = a_ge_s ? mb_s : ma_s;
    assign big_e_s     = a_ge_s ? ea_s : eb_s;
    assign small_e_s   = a_ge_s ? eb_s : ea_s;
    assign big_sign_s  = a_ge_s ? sa_s : sbe_s;
    assign big_x_s     = $signed({4'd0, big_e_s});
    assign eff_sub_s   = sa_s ^ sbe_s;
    assign exp_diff_s  = big_e_s - small_e_s;
    assign shamt_s     = (exp_diff_s > 8'd27) ? 5'd27 : exp_diff_s[4:0];
    assign shifted_s   = {small_m_s, 27'd0} >> shamt_s;
    assign small27_s   = {shifted_s[50:25], |shifted_s[24:0]};
    assign big27_s     = {big_m_s, 3'b000};
    assign sum_s       = {1'b0, big27_s} + {1'b0, small27_s};
    assign diff_s      = big27_s - small27_s;
    assign lz_s        = clz27(diff_s);
    assign diff_norm_s = diff_s << lz_s;

    // ---------------- mul/div datapath ----------------
    logic [47:0] prod_s;
    logic [49:0] num_s, den_s;
    logic [26:0] quo_s;
    logic        rem_nz_s;

    assign prod_s   = {24'd0, ma_s} * {24'd0, mb_s};
    assign num_s    = {ma_s, 26'd0};
    assign den_s    = (mb_s == 24'd0) ? 50'd1 : {26'd0, mb_s};
    assign quo_s    = 27'(num_s / den_s);
    assign rem_nz_s = (num_s % den_s) != 50'd0;

    // ---------------- result selection, rounding, packing ----------------
    logic               sp_hit_s, sp_err_s, r_zero_s, r_sign_s, r_g_s, r_st_s, inc_s;
    logic [31:0]        sp_y_s, res_y_s;
    logic               res_ovf_s, res_err_s;
    logic signed [11:0] r_exp_s, fin_exp_s;
    logic [23:0]        r_mant_s, fin_mant_s;
    logic [24:0]        mant25_s;

    // Pick special-case result or normalised mantissa/exponent per operation
    always_comb begin
        sp_hit_s = 1'b0;
        sp_err_s = 1'b0;
        sp_y_s   = 32'd0;
        r_zero_s = 1'b0;
        r_sign_s = 1'b0;
        r_exp_s  = 12'sd0;
        r_mant_s = 24'd0;
        r_g_s    = 1'b0;
        r_st_s   = 1'b0;
        if (a_nan_s || b_nan_s) begin
            sp_hit_s = 1'b1;
            sp_err_s = 1'b1;
            sp_y_s   = QNAN;
        end else begin
            case (sel_q)
                2'b00, 2'b01: begin
                    if (a_inf_s && b_inf_s && eff_sub_s) begin
                        sp_hit_s = 1'b1;
                        sp_err_s = 1'b1;
                        sp_y_s   = QNAN;
                    end else if (a_inf_s) begin
                        sp_hit_s = 1'b1;
                        sp_y_s   = {sa_s, INF_MAG};
                    end else if (b_inf_s) begin
                        sp_hit_s = 1'b1;
                        sp_y_s   = {sbe_s, INF_MAG};
                    end else if (!eff_sub_s) begin
                        r_sign_s = big_sign_s;
                        if (sum_s == 28'd0) begin
                            r_zero_s = 1'b1;
                            r_sign_s = sa_s;
                        end else if (sum_s[27]) begin
                            r_mant_s = sum_s[27:4];
                            r_g_s    = sum_s[3];
                            r_st_s   = |sum_s[2:0];
                            r_exp_s  = big_x_s + 12'sd1;
                        end else begin
                            r_mant_s = sum_s[26:3];
                            r_g_s    = sum_s[2];
                            r_st_s   = |sum_s[1:0];
                            r_exp_s  = big_x_s;
                        end
                    end else begin
                        r_sign_s = big_sign_s;
                        if (diff_s == 27'd0) begin
                            // Exact cancellation: -0 only when rounding toward -inf
                            r_zero_s = 1'b1;
                            r_sign_s = (round_q == 2'b11);
                        end else begin
                            r_mant_s = diff_norm_s[26:3];
                            r_g_s    = diff_norm_s[2];
                            r_st_s   = |diff_norm_s[1:0];
                            r_exp_s  = big_x_s - $signed({7'd0, lz_s});
                        end
                    end
                end
                2'b10: begin
                    r_sign_s = sa_s ^ sb_s;
                    if ((a_inf_s && b_zero_s) || (a_zero_s && b_inf_s)) begin
                        sp_hit_s = 1'b1;
                        sp_err_s = 1'b1;
                        sp_y_s   = QNAN;
                    end else if (a_inf_s || b_inf_s) begin
                        sp_hit_s = 1'b1;
                        sp_y_s   = {sa_s ^ sb_s, INF_MAG};
                    end else if (a_zero_s || b_zero_s) begin
                        sp_hit_s = 1'b1;
                        sp_y_s   = {sa_s ^ sb_s, 31'd0};
                    end else if (prod_s[47]) begin
                        r_mant_s = prod_s[47:24];
                        r_g_s    = prod_s[23];
                        r_st_s   = |prod_s[22:0];
                        r_exp_s  = ea_x_s + eb_x_s - 12'sd126;
                    end else begin
                        r_mant_s = prod_s[46:23];
                        r_g_s    = prod_s[22];
                        r_st_s   = |prod_s[21:0];
                        r_exp_s  = ea_x_s + eb_x_s - 12'sd127;
                    end
                end
                2'b11: begin
                    r_sign_s = sa_s ^ sb_s;
                    if ((a_inf_s && b_inf_s) || b_zero_s) begin
                        // inf/inf, 0/0 and any x/0 are invalid
                        sp_hit_s = 1'b1;
                        sp_err_s = 1'b1;
                        sp_y_s   = QNAN;
                    end else if (a_inf_s) begin
                        sp_hit_s = 1'b1;
                        sp_y_s   = {sa_s ^ sb_s, INF_MAG};
                    end else if (b_inf_s || a_zero_s) begin
                        sp_hit_s = 1'b1;
                        sp_y_s   = {sa_s ^ sb_s, 31'd0};
                    end else if (quo_s[26]) begin
                        r_mant_s = quo_s[26:3];
                        r_g_s    = quo_s[2];
                        r_st_s   = (|quo_s[1:0]) | rem_nz_s;
                        r_exp_s  = ea_x_s - eb_x_s + 12'sd127;
                    end else begin
                        r_mant_s = quo_s[25:2];
                        r_g_s    = quo_s[1];
                        r_st_s   = quo_s[0] | rem_nz_s;
                        r_exp_s  = ea_x_s - eb_x_s + 12'sd126;
                    end
                end
                default: begin
                    sp_hit_s = 1'b1;
                    sp_err_s = 1'b1;
                    sp_y_s   = QNAN;
                end
            endcase
        end
    end

    // Round the mantissa, renormalise on carry-out and pack with range checks
    always_comb begin
        case (round_q)
            2'b00:   inc_s = r_g_s & (r_st_s | r_mant_s[0]);
            2'b01:   inc_s = 1'b0;
            2'b10:   inc_s = ~r_sign_s & (r_g_s | r_st_s);
            2'b11:   inc_s = r_sign_s & (r_g_s | r_st_s);
            default: inc_s = 1'b0;
        endcase
        mant25_s = {1'b0, r_mant_s} + {24'd0, inc_s};
        if (mant25_s[24]) begin
            fin_mant_s = mant25_s[24:1];
            fin_exp_s  = r_exp_s + 12'sd1;
        end else begin
            fin_mant_s = mant25_s[23:0];
            fin_exp_s  = r_exp_s;
        end
        res_ovf_s = 1'b0;
        res_err_s = 1'b0;
        if (sp_hit_s) begin
            res_y_s   = sp_y_s;
            res_err_s = sp_err_s;
        end else if (r_zero_s) begin
            res_y_s = {r_sign_s, 31'd0};
        end else if (fin_exp_s >= 12'sd255) begin
            res_ovf_s = 1'b1;
            if ((round_q == 2'b00) || (round_q == 2'b10 && !r_sign_s) ||
                (round_q == 2'b11 && r_sign_s)) begin
                res_y_s = {r_sign_s, INF_MAG};
            end else begin
                res_y_s = {r_sign_s, MAX_MAG};
            end
        end else if (fin_exp_s <= 12'sd0) begin
            res_y_s = {r_sign_s, 31'd0};
        end else begin
            res_y_s = {r_sign_s, fin_exp_s[7:0], fin_mant_s[22:0]};
        end
    end

    // ---------------- control FSM ----------------
    // Next-state logic: IDLE waits for start, BUSY counts, DONE publishes
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_BUSY;
                    cnt_d   = 8'd0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State and latency counter registers
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Operand capture on an accepted start; later starts are ignored
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            sel_q   <= 2'b00;
            round_q <= 2'b00;
        end else if (state_q == ST_IDLE && start) begin
            a_q     <= A;
            b_q     <= B;
            sel_q   <= Sel;
            round_q <= round;
        end else begin
            a_q     <= a_q;
            b_q     <= b_q;
            sel_q   <= sel_q;
            round_q <= round_q;
        end
    end

    // Publish result and flags together on the DONE edge when generation is enabled
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            Y        <= 32'd0;
            Overflow <= 1'b0;
            Error    <= 1'b0;
        end else if (state_q == ST_DONE && genonly) begin
            Y        <= res_y_s;
            Overflow <= res_ovf_s;
            Error    <= res_err_s;
        end else begin
            Y        <= Y;
            Overflow <= Overflow;
            Error    <= Error;
        end
    end

endmodule

// File: tb/tb_pattern_generator.sv
// Directed self-checking bench for pattern_generator (LATENCY = 3).
module tb_pattern_generator;

    localparam int LAT = 3;

    logic        Clock = 1'b0;
    logic        Reset;
    logic [31:0] A, B, Y;
    logic [1:0]  Sel, round;
    logic        start, genonly, Error, Overflow;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  sel;
        logic [1:0]  rnd;
        logic        err;
        logic        ovf;
        logic [31:0] y;
    } vec_t;

    pattern_generator #(.LATENCY(LAT)) dut (
        .Clock   (Clock),
        .Reset   (Reset),
        .A       (A),
        .B       (B),
        .Sel     (Sel),
        .round   (round),
        .start   (start),
        .Error   (Error),
        .Overflow(Overflow),
        .Y       (Y),
        .genonly (genonly)
    );

    always #5 Clock = ~Clock;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // Drive one operation and wait until just after its result edge
    task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                         input logic [1:0] s, input logic [1:0] r);
        @(negedge Clock);
        A = a; B = b; Sel = s; round = r; start = 1'b1;
        @(negedge Clock);
        start = 1'b0;
        repeat (LAT) @(negedge Clock);
    endtask

    task automatic test_reset();
        Reset = 1'b1; A = 32'd0; B = 32'd0; Sel = 2'b00; round = 2'b00;
        start = 1'b0; genonly = 1'b1;
        repeat (2) @(negedge Clock);
        checks++;
        if ({Error, Overflow, Y} !== 34'd0) begin
            errors++;
            $display("FAIL reset: got err=%b ovf=%b y=%h, expected 0 0 00000000", Error, Overflow, Y);
        end
        Reset = 1'b0;
    endtask

    task automatic test_latency();
        @(negedge Clock);
        A = 32'h4370_0000; B = 32'h42F0_0000; Sel = 2'b00; round = 2'b00; start = 1'b1;
        @(negedge Clock);
        start = 1'b0;
        repeat (LAT - 1) @(negedge Clock);
        checks++;
        if (Y !== 32'h0000_0000) begin
            errors++;
            $display("FAIL latency_early: got y=%h one edge before result, expected 00000000", Y);
        end
        @(negedge Clock);
        checks++;
        if ({Error, Overflow, Y} !== {2'b00, 32'h43B4_0000}) begin
            errors++;
            $display("FAIL latency_on_time: got err=%b ovf=%b y=%h, expected 0 0 43b40000", Error, Overflow, Y);
        end
    endtask

    task automatic test_arith();
        vec_t v[6];
        v[0] = '{32'h4370_0000, 32'h42F0_0000, 2'b00, 2'b00, 1'b0, 1'b0, 32'h43B4_0000};
        v[1] = '{32'h4370_0000, 32'h42F0_0000, 2'b01, 2'b00, 1'b0, 1'b0, 32'h42F0_0000};
        v[2] = '{32'hC370_0000, 32'hC2F0_0000, 2'b10, 2'b00, 1'b0, 1'b0, 32'h46E1_0000};
        v[3] = '{32'h4370_0000, 32'hC2F0_0000, 2'b11, 2'b00, 1'b0, 1'b0, 32'hC000_0000};
        v[4] = '{32'h3F80_0000, 32'h3F40_0000, 2'b01, 2'b00, 1'b0, 1'b0, 32'h3E80_0000};
        v[5] = '{32'h0001_0000, 32'hFF01_0000, 2'b11, 2'b00, 1'b0, 1'b0, 32'h8000_0000};
        for (int i = 0; i < 6; i++) begin
            do_op(v[i].a, v[i].b, v[i].sel, v[i].rnd);
            checks++;
            if ({Error, Overflow, Y} !== {v[i].err, v[i].ovf, v[i].y}) begin
                errors++;
                $display("FAIL arith[%0d]: got err=%b ovf=%b y=%h, expected err=%b ovf=%b y=%h",
                         i, Error, Overflow, Y, v[i].err, v[i].ovf, v[i].y);
            end
        end
    endtask

    task automatic test_rounding();
        vec_t v[9];
        v[0] = '{32'h3F80_0000, 32'h33C0_0000, 2'b00, 2'b00, 1'b0, 1'b0, 32'h3F80_0001};
        v[1] = '{32'h3F80_0000, 32'h33C0_0000, 2'b00, 2'b01, 1'b0, 1'b0, 32'h3F80_0000};
        v[2] = '{32'h3F80_0000, 32'h33C0_0000, 2'b00, 2'b10, 1'b0, 1'b0, 32'h3F80_0001};
        v[3] = '{32'h3F80_0000, 32'h33C0_0000, 2'b00, 2'b11, 1'b0, 1'b0, 32'h3F80_0000};
        v[4] = '{32'hBF80_0000, 32'hB3C0_0000, 2'b00, 2'b11, 1'b0, 1'b0, 32'hBF80_0001};
        v[5] = '{32'hBF80_0000, 32'hB3C0_0000, 2'b00, 2'b10, 1'b0, 1'b0, 32'hBF80_0000};
        v[6] = '{32'h3F80_0000, 32'h3380_0000, 2'b00, 2'b00, 1'b0, 1'b0, 32'h3F80_0000};
        v[7] = '{32'h3F80_0001, 32'h3380_0000, 2'b00, 2'b00, 1'b0, 1'b0, 32'h3F80_0002};
        v[8] = '{32'h3F80_0000, 32'h3F80_0000, 2'b01, 2'b11, 1'b0, 1'b0, 32'h8000_0000};
        for (int i = 0; i < 9; i++) begin
            do_op(v[i].a, v[i].b, v[i].sel, v[i].rnd);
            checks++;
            if ({Error, Overflow, Y} !== {v[i].err, v[i].ovf, v[i].y}) begin
                errors++;
                $display("FAIL rounding[%0d]: got err=%b ovf=%b y=%h, expected err=%b ovf=%b y=%h",
                         i, Error, Overflow, Y, v[i].err, v[i].ovf, v[i].y);
            end
        end
    endtask

    task automatic test_overflow();
        vec_t v[6];
        v[0] = '{32'h7F01_0000, 32'h7F01_0000, 2'b00, 2'b00, 1'b0, 1'b1, 32'h7F80_0000};
        v[1] = '{32'h7F01_0000, 32'h7F01_0000, 2'b01, 2'b00, 1'b0, 1'b0, 32'h0000_0000};
        v[2] = '{32'h7F01_0000, 32'h7F01_0000, 2'b00, 2'b01, 1'b0, 1'b1, 32'h7F7F_FFFF};
        v[3] = '{32'hFF01_0000, 32'h7F01_0000, 2'b10, 2'b10, 1'b0, 1'b1, 32'hFF7F_FFFF};
        v[4] = '{32'hFF01_0000, 32'h7F01_0000, 2'b10, 2'b11, 1'b0, 1'b1, 32'hFF80_0000};
        v[5] = '{32'h0080_0000, 32'h0080_0000, 2'b10, 2'b00, 1'b0, 1'b0, 32'h0000_0000};
        for (int i = 0; i < 6; i++) begin
            do_op(v[i].a, v[i].b, v[i].sel, v[i].rnd);
            checks++;
            if ({Error, Overflow, Y} !== {v[i].err, v[i].ovf, v[i].y}) begin
                errors++;
                $display("FAIL overflow[%0d]: got err=%b ovf=%b y=%h, expected err=%b ovf=%b y=%h",
                         i, Error, Overflow, Y, v[i].err, v[i].ovf, v[i].y);
            end
        end
    endtask

    task automatic test_special();
        vec_t v[9];
        v[0] = '{32'h7F80_0000, 32'hFF80_0000, 2'b00, 2'b00, 1'b1, 1'b0, 32'h7FC0_0000};
        v[1] = '{32'h0000_0000, 32'h7F80_0000, 2'b10, 2'b00, 1'b1, 1'b0, 32'h7FC0_0000};
        v[2] = '{32'h0000_0000, 32'h0000_0000, 2'b11, 2'b00, 1'b1, 1'b0, 32'h7FC0_0000};
        v[3] = '{32'h7F80_0000, 32'h7F80_0000, 2'b11, 2'b00, 1'b1, 1'b0, 32'h7FC0_0000};
        v[4] = '{32'h3F80_0000, 32'h0000_0000, 2'b11, 2'b00, 1'b1, 1'b0, 32'h7FC0_0000};
        v[5] = '{32'h7FC0_0001, 32'h3F80_0000, 2'b00, 2'b00, 1'b1, 1'b0, 32'h7FC0_0000};
        v[6] = '{32'h7F80_0000, 32'h3F80_0000, 2'b00, 2'b00, 1'b0, 1'b0, 32'h7F80_0000};
        v[7] = '{32'hFF80_0000, 32'h4000_0000, 2'b10, 2'b00, 1'b0, 1'b0, 32'hFF80_0000};
        v[8] = '{32'h3F80_0000, 32'h7F80_0000, 2'b11, 2'b00, 1'b0, 1'b0, 32'h0000_0000};
        for (int i = 0; i < 9; i++) begin
            do_op(v[i].a, v[i].b, v[i].sel, v[i].rnd);
            checks++;
            if ({Error, Overflow, Y} !== {v[i].err, v[i].ovf, v[i].y}) begin
                errors++;
                $display("FAIL special[%0d]: got err=%b ovf=%b y=%h, expected err=%b ovf=%b y=%h",
                         i, Error, Overflow, Y, v[i].err, v[i].ovf, v[i].y);
            end
        end
    endtask

    task automatic test_start_ignored();
        @(negedge Clock);
        A = 32'h4370_0000; B = 32'h42F0_0000; Sel = 2'b00; round = 2'b00; start = 1'b1;
        @(negedge Clock);
        start = 1'b0;
        @(negedge Clock);
        // Busy now: change inputs and hold start across the BUSY and DONE edges
        A = 32'h3F80_0000; B = 32'h4000_0000; Sel = 2'b10; start = 1'b1;
        @(negedge Clock);
        @(negedge Clock);
        start = 1'b0;
        checks++;
        if ({Error, Overflow, Y} !== {2'b00, 32'h43B4_0000}) begin
            errors++;
            $display("FAIL start_ignored_result: got err=%b ovf=%b y=%h, expected 0 0 43b40000", Error, Overflow, Y);
        end
        repeat (5) @(negedge Clock);
        checks++;
        if (Y !== 32'h43B4_0000) begin
            errors++;
            $display("FAIL start_ignored_no_late: got y=%h, expected 43b40000", Y);
        end
    endtask

    task automatic test_genonly();
        genonly = 1'b0;
        do_op(32'h4370_0000, 32'h42F0_0000, 2'b10, 2'b00);
        checks++;
        if ({Error, Overflow, Y} !== {2'b00, 32'h43B4_0000}) begin
            errors++;
            $display("FAIL genonly_frozen: got err=%b ovf=%b y=%h, expected 0 0 43b40000", Error, Overflow, Y);
        end
        genonly = 1'b1;
        do_op(32'h4370_0000, 32'h42F0_0000, 2'b10, 2'b00);
        checks++;
        if ({Error, Overflow, Y} !== {2'b00, 32'h46E1_0000}) begin
            errors++;
            $display("FAIL genonly_resume: got err=%b ovf=%b y=%h, expected 0 0 46e10000", Error, Overflow, Y);
        end
    endtask

    task automatic test_reset_busy();
        do_op(32'h7F01_0000, 32'h7F01_0000, 2'b00, 2'b00);
        checks++;
        if ({Error, Overflow, Y} !== {2'b01, 32'h7F80_0000}) begin
            errors++;
            $display("FAIL reset_busy_pre: got err=%b ovf=%b y=%h, expected 0 1 7f800000", Error, Overflow, Y);
        end
        @(negedge Clock);
        A = 32'h4370_0000; B = 32'h42F0_0000; Sel = 2'b00; round = 2'b00; start = 1'b1;
        @(negedge Clock);
        start = 1'b0;
        @(negedge Clock);
        Reset = 1'b1;
        #1;
        checks++;
        if ({Error, Overflow, Y} !== 34'd0) begin
            errors++;
            $display("FAIL reset_busy_async: got err=%b ovf=%b y=%h, expected 0 0 00000000", Error, Overflow, Y);
        end
        @(negedge Clock);
        Reset = 1'b0;
        repeat (6) @(negedge Clock);
        checks++;
        if ({Error, Overflow, Y} !== 34'd0) begin
            errors++;
            $display("FAIL reset_busy_no_update: got err=%b ovf=%b y=%h, expected 0 0 00000000", Error, Overflow, Y);
        end
    endtask

    task automatic test_back_to_back();
        do_op(32'h4370_0000, 32'hC2F0_0000, 2'b11, 2'b00);
        checks++;
        if ({Error, Overflow, Y} !== {2'b00, 32'hC000_0000}) begin
            errors++;
            $display("FAIL back_to_back_0: got err=%b ovf=%b y=%h, expected 0 0 c0000000", Error, Overflow, Y);
        end
        do_op(32'h0000_0000, 32'h0000_0000, 2'b11, 2'b00);
        checks++;
        if ({Error, Overflow, Y} !== {2'b10, 32'h7FC0_0000}) begin
            errors++;
            $display("FAIL back_to_back_1: got err=%b ovf=%b y=%h, expected 1 0 7fc00000", Error, Overflow, Y);
        end
        do_op(32'h4370_0000, 32'h42F0_0000, 2'b01, 2'b00);
        checks++;
        if ({Error, Overflow, Y} !== {2'b00, 32'h42F0_0000}) begin
            errors++;
            $display("FAIL back_to_back_2: got err=%b ovf=%b y=%h, expected 0 0 42f00000", Error, Overflow, Y);
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_arith();
        test_rounding();
        test_overflow();
        test_special();
        test_start_ignored();
        test_genonly();
        test_reset_busy();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
